// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and timing constants for the ID-stage hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam int unsigned NREGS      = 16;
  localparam int unsigned REG_W      = 4;
  localparam int unsigned CNT_W      = 2;
  localparam int unsigned NOFWD_WAIT = 2;
  localparam int unsigned LOAD_WAIT  = 1;
  localparam int unsigned ALU_WAIT   = 0;
  localparam int unsigned STALL_W    = 16;

  typedef logic [REG_W-1:0] reg_idx_t;
  typedef logic [CNT_W-1:0] haz_cnt_t;

  // Decoded instruction as presented by IF/ID to the issue check.
  typedef struct packed {
    logic     valid;
    reg_idx_t src1;
    reg_idx_t src2;
    logic     is_imm;
    logic     st_or_bne;
    reg_idx_t dest;
    logic     wb_en;
    logic     mem_r_en;
    logic     br_taken;
  } id_req_t;

  // Cycles until a freshly issued result becomes readable by a dependent instruction.
  function automatic haz_cnt_t wait_cycles(input logic fwd_en, input logic is_load);
    if (!fwd_en) begin
      return CNT_W'(NOFWD_WAIT);
    end
    return is_load ? CNT_W'(LOAD_WAIT) : CNT_W'(ALU_WAIT);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request and issue/stall response bundle for the hazard scoreboard.
interface hazard_scoreboard_if;
  import hazard_scoreboard_pkg::*;

  logic                fwd_en;
  id_req_t             id;
  logic                hazard_detected;
  logic                flush_if_id;
  logic                issue;
  logic [STALL_W-1:0]  stall_count;

  modport master (
    output fwd_en, id,
    input  hazard_detected, flush_if_id, issue, stall_count
  );

  modport slave (
    input  fwd_en, id,
    output hazard_detected, flush_if_id, issue, stall_count
  );

endinterface

// File: rtl/hazard_scoreboard_entry.sv
// One register's countdown of cycles until its in-flight result is readable.
module scoreboard_entry
  import hazard_scoreboard_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_load,
  input  haz_cnt_t i_load_val,
  output logic     o_busy
);

  haz_cnt_t r_cnt;

  // A new writer overrides whatever is in flight; otherwise count down to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage issue controller: stalls on pending source results and flushes IF/ID on taken branches.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  hazard_scoreboard_if.slave bus
);

  logic [NREGS-1:0]   w_busy;
  logic [NREGS-1:0]   w_load;
  haz_cnt_t           w_load_val;
  logic               w_uses_src2;
  logic               w_eff_valid;
  logic               w_hazard;
  logic               w_issue;
  logic               w_flush;
  logic               r_squash;
  logic [STALL_W-1:0] r_stall_count;

  // Outputs are forced low while reset is held, even though they are combinational.
  assign w_uses_src2 = ~bus.id.is_imm | bus.id.st_or_bne;
  assign w_eff_valid = rst_n & bus.id.valid & ~r_squash;
  assign w_hazard    = w_eff_valid &
                       (w_busy[bus.id.src1] | (w_uses_src2 & w_busy[bus.id.src2]));
  assign w_issue     = w_eff_valid & ~w_hazard;
  assign w_flush     = w_issue & bus.id.br_taken;
  assign w_load_val  = wait_cycles(bus.fwd_en, bus.id.mem_r_en);

  always_comb begin
    w_load = '0;
    if (w_issue && bus.id.wb_en) begin
      w_load[bus.id.dest] = 1'b1;
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_entry
    scoreboard_entry u_entry (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_load[g]),
      .i_load_val (w_load_val),
      .o_busy     (w_busy[g])
    );
  end

  // Squash forces exactly one non-issue cycle after a flush; stall count saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_squash      <= 1'b0;
      r_stall_count <= '0;
    end else begin
      r_squash <= w_flush;
      if (w_hazard && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + STALL_W'(1);
      end
    end
  end

  assign bus.hazard_detected = w_hazard;
  assign bus.issue           = w_issue;
  assign bus.flush_if_id     = w_flush;
  assign bus.stall_count     = r_stall_count;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: directed scenarios plus a model-driven random run.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  typedef struct packed {
    logic        haz;
    logic        iss;
    logic        fl;
    logic [15:0] sc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if u_if();

  hazard_scoreboard u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  exp_t        exp_q[$];
  int          errors  = 0;
  int          checks  = 0;
  logic [15:0] sc_exp  = '0;

  function automatic id_req_t mk(input logic v, input int s1, input int s2, input logic imm,
                                 input logic sb, input int d, input logic wb, input logic mr,
                                 input logic br);
    id_req_t r;
    r.valid = v; r.src1 = 4'(s1); r.src2 = 4'(s2); r.is_imm = imm; r.st_or_bne = sb;
    r.dest = 4'(d); r.wb_en = wb; r.mem_r_en = mr; r.br_taken = br;
    return r;
  endfunction

  function automatic exp_t ex_v(input logic h, input logic i, input logic f, input logic [15:0] s);
    exp_t e;
    e.haz = h; e.iss = i; e.fl = f; e.sc = s;
    return e;
  endfunction

  function automatic exp_t observed();
    return ex_v(u_if.hazard_detected, u_if.issue, u_if.flush_if_id, u_if.stall_count);
  endfunction

  function automatic string fmt(input exp_t v);
    return $sformatf("haz=%b issue=%b flush=%b stalls=%0d", v.haz, v.iss, v.fl, v.sc);
  endfunction

  task automatic test_reset();
    exp_t e, got;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      u_if.fwd_en = 1'($urandom_range(0, 1));
      u_if.id     = id_req_t'($urandom());
      u_if.id.valid = 1'b1;
      exp_q.push_back(ex_v(1'b0, 1'b0, 1'b0, 16'd0));
      @(negedge clk);
      got = observed(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++; $display("FAIL reset_hold[%0d] got %s want %s", i, fmt(got), fmt(e));
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    u_if.fwd_en = 1'b1;
    u_if.id = mk(1, 1, 2, 0, 0, 3, 1, 0, 0);
    exp_q.push_back(ex_v(1'b0, 1'b1, 1'b0, 16'd0));
    @(negedge clk);
    got = observed(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      errors++; $display("FAIL reset_release got %s want %s", fmt(got), fmt(e));
    end
    @(posedge clk); #1;
    sc_exp = 16'd0;
  endtask

  task automatic test_load_use();
    id_req_t st[$]; exp_t ex[$]; exp_t e, got;
    u_if.fwd_en = 1'b1;
    st.push_back(mk(1, 1, 2, 0, 0, 3, 1, 1, 0)); ex.push_back(ex_v(0, 1, 0, sc_exp));
    st.push_back(mk(1, 3, 5, 0, 0, 4, 1, 0, 0)); ex.push_back(ex_v(1, 0, 0, sc_exp));
    st.push_back(mk(1, 3, 5, 0, 0, 4, 1, 0, 0)); ex.push_back(ex_v(0, 1, 0, sc_exp + 16'd1));
    foreach (st[i]) begin
      u_if.id = st[i]; exp_q.push_back(ex[i]);
      @(negedge clk);
      got = observed(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++; $display("FAIL load_use[%0d] got %s want %s", i, fmt(got), fmt(e));
      end
      @(posedge clk); #1;
    end
    sc_exp += 16'd1;
  endtask

  task automatic test_no_forward();
    id_req_t st[$]; exp_t ex[$]; exp_t e, got;
    u_if.fwd_en = 1'b0;
    st.push_back(mk(1, 1, 1, 0, 0, 2, 1, 0, 0)); ex.push_back(ex_v(0, 1, 0, sc_exp));
    st.push_back(mk(1, 0, 2, 0, 0, 5, 0, 0, 0)); ex.push_back(ex_v(1, 0, 0, sc_exp));
    st.push_back(mk(1, 0, 2, 0, 0, 5, 0, 0, 0)); ex.push_back(ex_v(1, 0, 0, sc_exp + 16'd1));
    st.push_back(mk(1, 0, 2, 0, 0, 5, 0, 0, 0)); ex.push_back(ex_v(0, 1, 0, sc_exp + 16'd2));
    st.push_back(mk(1, 0, 1, 0, 0, 2, 1, 0, 0)); ex.push_back(ex_v(0, 1, 0, sc_exp + 16'd2));
    st.push_back(mk(1, 0, 2, 1, 0, 5, 0, 0, 0)); ex.push_back(ex_v(0, 1, 0, sc_exp + 16'd2));
    st.push_back(mk(1, 0, 2, 1, 1, 5, 0, 0, 0)); ex.push_back(ex_v(1, 0, 0, sc_exp + 16'd2));
    st.push_back(mk(1, 0, 2, 1, 1, 5, 0, 0, 0)); ex.push_back(ex_v(0, 1, 0, sc_exp + 16'd3));
    foreach (st[i]) begin
      u_if.id = st[i]; exp_q.push_back(ex[i]);
      @(negedge clk);
      got = observed(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++; $display("FAIL no_forward[%0d] got %s want %s", i, fmt(got), fmt(e));
      end
      @(posedge clk); #1;
    end
    sc_exp += 16'd3;
  endtask

  task automatic test_branch();
    id_req_t st[$]; exp_t ex[$]; exp_t e, got;
    u_if.fwd_en = 1'b1;
    st.push_back(mk(1, 1, 2, 1, 1, 0, 0, 0, 1)); ex.push_back(ex_v(0, 1, 1, sc_exp));
    st.push_back(mk(1, 3, 4, 0, 0, 5, 1, 0, 0)); ex.push_back(ex_v(0, 0, 0, sc_exp));
    st.push_back(mk(1, 3, 4, 0, 0, 5, 1, 0, 0)); ex.push_back(ex_v(0, 1, 0, sc_exp));
    st.push_back(mk(1, 0, 1, 0, 0, 8, 1, 1, 0)); ex.push_back(ex_v(0, 1, 0, sc_exp));
    st.push_back(mk(1, 0, 8, 1, 1, 0, 0, 0, 1)); ex.push_back(ex_v(1, 0, 0, sc_exp));
    st.push_back(mk(1, 0, 8, 1, 1, 0, 0, 0, 1)); ex.push_back(ex_v(0, 1, 1, sc_exp + 16'd1));
    st.push_back(mk(1, 0, 1, 0, 0, 9, 1, 0, 0)); ex.push_back(ex_v(0, 0, 0, sc_exp + 16'd1));
    st.push_back(mk(0, 0, 1, 0, 0, 9, 1, 0, 1)); ex.push_back(ex_v(0, 0, 0, sc_exp + 16'd1));
    foreach (st[i]) begin
      u_if.id = st[i]; exp_q.push_back(ex[i]);
      @(negedge clk);
      got = observed(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++; $display("FAIL branch[%0d] got %s want %s", i, fmt(got), fmt(e));
      end
      @(posedge clk); #1;
    end
    sc_exp += 16'd1;
  endtask

  task automatic test_waw();
    id_req_t st[$]; exp_t ex[$]; logic fw[$]; exp_t e, got;
    fw.push_back(1); st.push_back(mk(1, 0, 1, 0, 0, 6, 1, 1, 0)); ex.push_back(ex_v(0, 1, 0, sc_exp));
    fw.push_back(1); st.push_back(mk(1, 0, 1, 0, 0, 6, 1, 0, 0)); ex.push_back(ex_v(0, 1, 0, sc_exp));
    fw.push_back(1); st.push_back(mk(1, 6, 1, 0, 0, 7, 0, 0, 0)); ex.push_back(ex_v(0, 1, 0, sc_exp));
    fw.push_back(0); st.push_back(mk(1, 0, 1, 0, 0, 6, 1, 0, 0)); ex.push_back(ex_v(0, 1, 0, sc_exp));
    fw.push_back(0); st.push_back(mk(1, 0, 1, 0, 0, 6, 1, 0, 0)); ex.push_back(ex_v(0, 1, 0, sc_exp));
    fw.push_back(0); st.push_back(mk(1, 6, 6, 0, 0, 7, 0, 0, 0)); ex.push_back(ex_v(1, 0, 0, sc_exp));
    fw.push_back(0); st.push_back(mk(1, 6, 6, 0, 0, 7, 0, 0, 0)); ex.push_back(ex_v(1, 0, 0, sc_exp + 16'd1));
    fw.push_back(0); st.push_back(mk(1, 6, 6, 0, 0, 7, 0, 0, 0)); ex.push_back(ex_v(0, 1, 0, sc_exp + 16'd2));
    foreach (st[i]) begin
      u_if.fwd_en = fw[i]; u_if.id = st[i]; exp_q.push_back(ex[i]);
      @(negedge clk);
      got = observed(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++; $display("FAIL waw[%0d] got %s want %s", i, fmt(got), fmt(e));
      end
      @(posedge clk); #1;
    end
    sc_exp += 16'd2;
  endtask

  task automatic test_reset_mid();
    id_req_t st[$]; exp_t ex[$]; logic rs[$]; exp_t e, got;
    u_if.fwd_en = 1'b0;
    rs.push_back(1); st.push_back(mk(1, 0, 1, 0, 0, 10, 1, 0, 0)); ex.push_back(ex_v(0, 1, 0, sc_exp));
    rs.push_back(0); st.push_back(mk(1, 10, 1, 0, 0, 7, 0, 0, 0)); ex.push_back(ex_v(0, 0, 0, 16'd0));
    rs.push_back(1); st.push_back(mk(1, 10, 1, 0, 0, 7, 0, 0, 0)); ex.push_back(ex_v(0, 1, 0, 16'd0));
    foreach (st[i]) begin
      rst_n = rs[i]; u_if.id = st[i]; exp_q.push_back(ex[i]);
      @(negedge clk);
      got = observed(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++; $display("FAIL reset_mid[%0d] got %s want %s", i, fmt(got), fmt(e));
      end
      @(posedge clk); #1;
    end
    sc_exp = 16'd0;
  endtask

  // Independent behavioural model of the scoreboard, driven with random traffic.
  task automatic test_random();
    int          m_cnt[16];
    logic        m_sq;
    logic [15:0] m_sc;
    logic        ev, u2, h, iss, fl;
    id_req_t     r;
    exp_t        e, got;
    foreach (m_cnt[k]) m_cnt[k] = 0;
    m_sq = 1'b0; m_sc = sc_exp;
    for (int ph = 0; ph < 2; ph++) begin
      u_if.fwd_en = (ph == 1);
      for (int c = 0; c < 200; c++) begin
        r = id_req_t'($urandom());
        r.src1 = 4'($urandom_range(0, 3)); r.src2 = 4'($urandom_range(0, 3));
        r.dest = 4'($urandom_range(0, 3));
        r.valid = (c < 197) && ($urandom_range(0, 9) < 8);
        r.br_taken = ($urandom_range(0, 4) == 0);
        u_if.id = r;
        ev  = r.valid & ~m_sq;
        u2  = ~r.is_imm | r.st_or_bne;
        h   = ev & ((m_cnt[r.src1] != 0) | (u2 & (m_cnt[r.src2] != 0)));
        iss = ev & ~h;
        fl  = iss & r.br_taken;
        exp_q.push_back(ex_v(h, iss, fl, m_sc));
        @(negedge clk);
        got = observed(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin
          errors++; $display("FAIL random[%0d.%0d] got %s want %s", ph, c, fmt(got), fmt(e));
        end
        for (int k = 0; k < 16; k++) begin
          if (iss && r.wb_en && (int'(r.dest) == k)) m_cnt[k] = (ph == 1) ? (r.mem_r_en ? 1 : 0) : 2;
          else if (m_cnt[k] != 0) m_cnt[k] = m_cnt[k] - 1;
        end
        m_sq = fl;
        if (h && (m_sc != 16'hFFFF)) m_sc = m_sc + 16'd1;
        @(posedge clk); #1;
      end
    end
    sc_exp = m_sc;
  endtask

  initial begin
    u_if.fwd_en = 1'b0;
    u_if.id     = '0;
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_no_forward();
    test_branch();
    test_waw();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
